// File: rtl/delay_ctrl_pkg.sv
// Shared register-map offsets and value helpers for the multi-channel delay controller.
package delay_ctrl_pkg;

  localparam int unsigned DELAY_BASE = 0;

  function automatic int unsigned delay_ofs(input int unsigned ch);
    return DELAY_BASE + ch;
  endfunction

  function automatic int unsigned ctrl_ofs(input int unsigned nch);
    return nch;
  endfunction

  function automatic int unsigned status_ofs(input int unsigned nch);
    return nch + 1;
  endfunction

  // Counter must hold the value REPEAT_CYC itself.
  function automatic int unsigned cnt_width(input int unsigned repeat_cyc);
    return $clog2(repeat_cyc + 1);
  endfunction

  function automatic logic [31:0] clamp_dly(input logic [31:0] v,
                                            input logic [31:0] lo,
                                            input logic [31:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic logic out_of_range(input logic [31:0] v,
                                        input logic [31:0] lo,
                                        input logic [31:0] hi);
    return (v < lo) || (v > hi);
  endfunction

endpackage

// File: rtl/delay_ctrl_multi_if.sv
// Avalon-MM slave bus bundle for the delay controller register file.
interface delay_ctrl_multi_if #(
  parameter int AW = 3
);
  logic [AW-1:0] address;
  logic          chipselect;
  logic          read;
  logic          write;
  logic [31:0]   writedata;
  logic [31:0]   readdata;

  modport master (output address, chipselect, read, write, writedata, input readdata);
  modport slave  (input address, chipselect, read, write, writedata, output readdata);
endinterface

// File: rtl/delay_ctrl_chan.sv
// One delay channel: button edge detect, hold-to-repeat, saturation and bus load.
module delay_ctrl_chan
  import delay_ctrl_pkg::*;
#(
  parameter int DW         = 4,
  parameter int MIN_DLY    = 1,
  parameter int MAX_DLY    = 15,
  parameter int RST_DLY    = 8,
  parameter int REPEAT_CYC = 1000000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          faster,
  input  logic          slower,
  input  logic          lock,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_val,
  input  logic          wr_oor,
  output logic [DW-1:0] dly,
  output logic          limit_evt
);
  localparam int            CW      = cnt_width(REPEAT_CYC);
  localparam logic [CW-1:0] CNT_TOP = CW'(REPEAT_CYC);
  localparam logic [DW-1:0] LO      = DW'(MIN_DLY);
  localparam logic [DW-1:0] HI      = DW'(MAX_DLY);
  localparam logic [DW-1:0] INIT    = DW'(RST_DLY);

  logic          faster_q, slower_q;
  logic [CW-1:0] cnt;
  logic          held, edge_det, rpt, step, blocked;

  always_comb begin
    held      = (faster ^ slower) & ~lock;
    edge_det  = held & (faster ? ~faster_q : ~slower_q);
    rpt       = held & (cnt == CNT_TOP);
    step      = edge_det | rpt;
    blocked   = faster ? (dly <= LO) : (dly >= HI);
    limit_evt = wr_en ? wr_oor : (step & blocked);
  end

  // The counter only arms on a real edge, so a button already held when the
  // channel is unlocked never starts repeating by itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      faster_q <= 1'b0;
      slower_q <= 1'b0;
      cnt      <= '0;
      dly      <= INIT;
    end else begin
      faster_q <= faster;
      slower_q <= slower;
      if (!held)                cnt <= '0;
      else if (edge_det || rpt) cnt <= CW'(1);
      else if (cnt != '0)       cnt <= cnt + 1'b1;

      if (wr_en)                  dly <= wr_val;
      else if (step && !blocked)  dly <= faster ? dly - 1'b1 : dly + 1'b1;
    end
  end

endmodule

// File: rtl/delay_ctrl_multi.sv
// Multi-channel delay controller: per-channel stepping plus bus-visible delay, lock and status registers.
module delay_ctrl_multi
  import delay_ctrl_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int DW         = 4,
  parameter int MIN_DLY    = 1,
  parameter int MAX_DLY    = 15,
  parameter int RST_DLY    = 8,
  parameter int REPEAT_CYC = 1000000,
  parameter int AW         = $clog2(NCH + 2)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NCH-1:0]      faster,
  input  logic [NCH-1:0]      slower,
  output logic [NCH*DW-1:0]   delay,
  delay_ctrl_multi_if.slave   bus
);
  localparam logic [31:0] CTRL_A   = 32'(ctrl_ofs(NCH));
  localparam logic [31:0] STATUS_A = 32'(status_ofs(NCH));

  logic [AW-1:0]  addr;
  logic [31:0]    addr_w;
  logic           wr_sel, rd_sel, wr_oor;
  logic [DW-1:0]  wr_val;
  logic [DW-1:0]  dly [NCH];
  logic [NCH-1:0] lock, status, limit_evt, status_clr, dly_wr;
  logic [31:0]    rd_mux;

  assign addr   = bus.address;
  assign addr_w = 32'(addr);
  assign wr_sel = bus.chipselect & bus.write;
  assign rd_sel = bus.chipselect & bus.read;
  assign wr_val = DW'(clamp_dly(bus.writedata, 32'(MIN_DLY), 32'(MAX_DLY)));
  assign wr_oor = out_of_range(bus.writedata, 32'(MIN_DLY), 32'(MAX_DLY));

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    assign dly_wr[i] = wr_sel && (addr_w == 32'(delay_ofs(i)));

    delay_ctrl_chan #(
      .DW(DW), .MIN_DLY(MIN_DLY), .MAX_DLY(MAX_DLY),
      .RST_DLY(RST_DLY), .REPEAT_CYC(REPEAT_CYC)
    ) u_chan (
      .clk(clk), .reset(reset),
      .faster(faster[i]), .slower(slower[i]), .lock(lock[i]),
      .wr_en(dly_wr[i]), .wr_val(wr_val), .wr_oor(wr_oor),
      .dly(dly[i]), .limit_evt(limit_evt[i])
    );

    assign delay[i*DW +: DW] = dly[i];
  end

  assign status_clr = (wr_sel && addr_w == STATUS_A) ? bus.writedata[NCH-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NCH; i++)
      if (addr_w == 32'(delay_ofs(i))) rd_mux = 32'(dly[i]);
    if (addr_w == CTRL_A)   rd_mux = 32'(lock);
    if (addr_w == STATUS_A) rd_mux = 32'(status);
  end

  // New limit events are OR-ed in after the clear so they win over a W1C.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock         <= '0;
      status       <= '0;
      bus.readdata <= '0;
    end else begin
      if (wr_sel && addr_w == CTRL_A) lock <= bus.writedata[NCH-1:0];
      status <= (status & ~status_clr) | limit_evt;
      if (rd_sel) bus.readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_delay_ctrl_multi.sv
// Directed self-checking bench for delay_ctrl_multi with a short repeat period.
module tb_delay_ctrl_multi;
  localparam int NCH = 4;
  localparam int DW  = 4;
  localparam int AW  = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH-1:0]    faster, slower;
  logic [NCH*DW-1:0] delay;
  logic [31:0]       rd;
  int                errors = 0;
  int                checks = 0;

  delay_ctrl_multi_if #(.AW(AW)) bus_if ();

  delay_ctrl_multi #(
    .NCH(NCH), .DW(DW), .MIN_DLY(1), .MAX_DLY(15), .RST_DLY(8),
    .REPEAT_CYC(4), .AW(AW)
  ) dut (
    .clk(clk), .reset(reset), .faster(faster), .slower(slower),
    .delay(delay), .bus(bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [AW-1:0] a, input logic [31:0] d);
    bus_if.address    = a;
    bus_if.writedata  = d;
    bus_if.chipselect = 1'b1;
    bus_if.write      = 1'b1;
    tick(1);
    bus_if.chipselect = 1'b0;
    bus_if.write      = 1'b0;
  endtask

  task automatic bus_read(input logic [AW-1:0] a, output logic [31:0] d);
    bus_if.address    = a;
    bus_if.chipselect = 1'b1;
    bus_if.read       = 1'b1;
    tick(1);
    bus_if.chipselect = 1'b0;
    bus_if.read       = 1'b0;
    d = bus_if.readdata;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    checks++;
    if (bus_if.readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %0h expected 0", bus_if.readdata); end
    checks++;
    if (delay !== 16'h8888) begin errors++; $display("FAIL reset_delay_bus: got %0h expected 8888", delay); end
    for (int i = 0; i < NCH; i++) begin
      bus_read(AW'(i), rd);
      checks++;
      if (rd !== 32'd8) begin errors++; $display("FAIL reset_delay%0d: got %0h expected 8", i, rd); end
    end
    bus_read(3'd4, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %0h expected 0", rd); end
    bus_read(3'd5, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_status: got %0h expected 0", rd); end
    bus_read(3'd3, rd);
    bus_read(3'd6, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %0h expected 0", rd); end
  endtask

  task automatic test_step();
    faster[1] = 1'b1;
    tick(1);
    faster[1] = 1'b0;
    checks++;
    if (delay !== 16'h8878) begin errors++; $display("FAIL step_faster1: got %0h expected 8878", delay); end
    // edge step at hold cycle 0, repeats at 4, 8, 12
    slower[2] = 1'b1;
    tick(13);
    slower[2] = 1'b0;
    tick(1);
    checks++;
    if (delay !== 16'h8C78) begin errors++; $display("FAIL repeat_slower2: got %0h expected 8c78", delay); end
    bus_read(3'd2, rd);
    checks++;
    if (rd !== 32'd12) begin errors++; $display("FAIL repeat_read2: got %0h expected c", rd); end
  endtask

  task automatic test_saturation();
    bus_write(3'd0, 32'd2);
    checks++;
    if (delay !== 16'h8C72) begin errors++; $display("FAIL write_delay0: got %0h expected 8c72", delay); end
    faster[0] = 1'b1;
    tick(1);
    bus_read(3'd5, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL exact_bound_no_flag: got %0h expected 0", rd); end
    tick(8);
    faster[0] = 1'b0;
    checks++;
    if (delay !== 16'h8C71) begin errors++; $display("FAIL min_saturate: got %0h expected 8c71", delay); end
    bus_read(3'd5, rd);
    checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL min_flag: got %0h expected 1", rd); end
    bus_write(3'd5, 32'h1);
    bus_read(3'd5, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL status_w1c: got %0h expected 0", rd); end

    bus_write(3'd3, 32'd0);
    checks++;
    if (delay !== 16'h1C71) begin errors++; $display("FAIL clamp_low: got %0h expected 1c71", delay); end
    bus_read(3'd5, rd);
    checks++;
    if (rd !== 32'h8) begin errors++; $display("FAIL clamp_flag: got %0h expected 8", rd); end
    bus_write(3'd3, 32'd15);
    slower[3] = 1'b1;
    tick(1);
    slower[3] = 1'b0;
    tick(1);
    checks++;
    if (delay !== 16'hFC71) begin errors++; $display("FAIL max_saturate: got %0h expected fc71", delay); end
  endtask

  task automatic test_lock();
    bus_write(3'd4, 32'h4);
    bus_read(3'd4, rd);
    checks++;
    if (rd !== 32'h4) begin errors++; $display("FAIL ctrl_read: got %0h expected 4", rd); end
    slower[2] = 1'b1;
    tick(1);
    slower[2] = 1'b0;
    tick(1);
    checks++;
    if (delay !== 16'hFC71) begin errors++; $display("FAIL locked_pulse: got %0h expected fc71", delay); end
    slower[2] = 1'b1;
    tick(2);
    bus_write(3'd4, 32'h0);
    tick(8);
    checks++;
    if (delay !== 16'hFC71) begin errors++; $display("FAIL unlock_while_held: got %0h expected fc71", delay); end
    slower[2] = 1'b0;
    tick(1);
    slower[2] = 1'b1;
    tick(1);
    slower[2] = 1'b0;
    tick(1);
    checks++;
    if (delay !== 16'hFD71) begin errors++; $display("FAIL repress_after_unlock: got %0h expected fd71", delay); end
  endtask

  task automatic test_back_to_back();
    faster[1] = 1'b1;
    bus_write(3'd1, 32'd5);
    faster[1] = 1'b0;
    tick(1);
    checks++;
    if (delay !== 16'hFD51) begin errors++; $display("FAIL write_beats_step: got %0h expected fd51", delay); end
    bus_write(3'd7, 32'hFFFF_FFFF);
    checks++;
    if (delay !== 16'hFD51) begin errors++; $display("FAIL unmapped_write_delay: got %0h expected fd51", delay); end
    bus_read(3'd4, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL unmapped_write_ctrl: got %0h expected 0", rd); end
    bus_read(3'd5, rd);
    checks++;
    if (rd !== 32'h8) begin errors++; $display("FAIL status_sticky: got %0h expected 8", rd); end
    bus_read(3'd2, rd);
    tick(3);
    checks++;
    if (bus_if.readdata !== 32'hD) begin errors++; $display("FAIL readdata_hold: got %0h expected d", bus_if.readdata); end
  endtask

  task automatic test_reset_mid_repeat();
    slower[0] = 1'b1;
    tick(6);
    checks++;
    if (delay !== 16'hFD53) begin errors++; $display("FAIL pre_reset_repeat: got %0h expected fd53", delay); end
    reset = 1'b1;
    tick(2);
    slower[0] = 1'b0;
    tick(1);
    reset = 1'b0;
    checks++;
    if (delay !== 16'h8888) begin errors++; $display("FAIL mid_reset_delay: got %0h expected 8888", delay); end
    tick(1);
    checks++;
    if (delay !== 16'h8888) begin errors++; $display("FAIL post_reset_no_step: got %0h expected 8888", delay); end
    checks++;
    if (bus_if.readdata !== 32'h0) begin errors++; $display("FAIL mid_reset_readdata: got %0h expected 0", bus_if.readdata); end
    bus_read(3'd5, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL mid_reset_status: got %0h expected 0", rd); end
  endtask

  initial begin
    reset             = 1'b1;
    faster            = '0;
    slower            = '0;
    bus_if.address    = '0;
    bus_if.chipselect = 1'b0;
    bus_if.read       = 1'b0;
    bus_if.write      = 1'b0;
    bus_if.writedata  = '0;
    test_reset();
    test_step();
    test_saturation();
    test_lock();
    test_back_to_back();
    test_reset_mid_repeat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
